// File: rtl/ahb_slave_port_arbiter_pkg.sv
// Shared AHB types for slave-port arbitration: transfer/burst encodings, arbiter FSM states,
// and the beat-count lookup for fixed-length bursts.
package ahb_slave_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BURST,
        ARB_INCR,
        ARB_LOCK
    } arb_state_t;

    localparam int HMASTER_W = 4;

    function automatic logic [4:0] burst_beats(input hburst_t b);
        case (b)
            WRAP4, INCR4:   return 5'd4;
            WRAP8, INCR8:   return 5'd8;
            WRAP16, INCR16: return 5'd16;
            default:        return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin pick: first set req bit after ptr (wrapping), as one-hot gnt.
// Zero latency; no flow control, vld low when nothing requests.
module ahb_rr_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!vld && req[idx]) begin
                gnt[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_port_arbiter.sv
// Round-robin AHB arbiter for one shared slave port, holding grant through bursts, INCR and locks.
// Grant changes one cycle after the deciding edge; every register freezes while hready is low.
module ahb_slave_port_arbiter
    import ahb_slave_port_arbiter_pkg::*;
#(
    parameter int MASTER_NUM  = 2,
    parameter int DEFAULT_MAS = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [MASTER_NUM-1:0] hreq,
    input  logic [MASTER_NUM-1:0] hlock,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hburst,
    input  logic                  hready,
    output logic [MASTER_NUM-1:0] addr_sel,
    output logic [MASTER_NUM-1:0] data_sel,
    output logic [HMASTER_W-1:0]  hmaster,
    output logic                  hmastlock
);

    localparam int PW = $clog2(MASTER_NUM);
    localparam logic [MASTER_NUM-1:0] PARK_SEL = MASTER_NUM'(1) << DEFAULT_MAS;

    arb_state_t            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [MASTER_NUM-1:0] addr_sel_d;
    logic [MASTER_NUM-1:0] pick_gnt;
    logic                  pick_vld;
    logic [PW-1:0]         pick_idx;
    logic                  rearb;
    logic                  owner_req, owner_lock;
    htrans_t               tr;
    hburst_t               bu;

    assign tr         = htrans_t'(htrans);
    assign bu         = hburst_t'(hburst);
    assign owner_req  = |(hreq & addr_sel);
    assign owner_lock = |(hlock & addr_sel);
    assign hmastlock  = (state_q == ARB_LOCK);

    ahb_rr_picker #(.N(MASTER_NUM), .PW(PW)) u_picker (
        .req (hreq),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        hmaster  = '0;
        pick_idx = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (addr_sel[i]) hmaster  = hmaster | HMASTER_W'(i);
            if (pick_gnt[i]) pick_idx = pick_idx | PW'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rearb   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                rearb = 1'b1;
                if (tr == NONSEQ) begin
                    if (owner_lock) begin
                        state_d = ARB_LOCK;
                        rearb   = 1'b0;
                    end else if (bu == INCR) begin
                        state_d = ARB_INCR;
                        rearb   = 1'b0;
                    end else if (bu != SINGLE) begin
                        state_d = ARB_BURST;
                        cnt_d   = 4'(burst_beats(bu) - 5'd1);
                        rearb   = 1'b0;
                    end
                end
            end
            ARB_BURST: begin
                // Last beat re-arbitrates on its own edge so the next owner follows back-to-back.
                if (tr == IDLE) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                    rearb   = 1'b1;
                end else if (tr == SEQ) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ARB_IDLE;
                        rearb   = 1'b1;
                    end
                end
            end
            ARB_INCR: begin
                if (!owner_req || tr == IDLE) begin
                    state_d = ARB_IDLE;
                    rearb   = 1'b1;
                end
            end
            ARB_LOCK: begin
                // No re-arbitration on exit: the owner keeps the bus one more cycle.
                if (!owner_lock) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        addr_sel_d = addr_sel;
        ptr_d      = ptr_q;
        if (rearb) begin
            if (pick_vld) begin
                addr_sel_d = pick_gnt;
                ptr_d      = pick_idx;
            end else begin
                addr_sel_d = PARK_SEL;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            ptr_q    <= PW'(DEFAULT_MAS);
            addr_sel <= PARK_SEL;
            data_sel <= PARK_SEL;
        end else if (hready) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            addr_sel <= addr_sel_d;
            data_sel <= addr_sel;
        end
    end

endmodule
